id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_pkg.sv | 24 ++
 rtl/id_ex_reg_sat_counter.sv | 31 +++
 rtl/id_ex_reg.sv | 161 ++++++++++++++++
 tb/tb_id_ex_reg.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline definitions: datapath widths and the packed EX control bundle.
package id_ex_reg_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_AW    = 5;
   localparam int unsigned ALUCTR_W  = 4;
   localparam int unsigned ALUBSRC_W = 2;

   typedef struct packed {
      logic                 mem_wr;
      logic                 branch;
      logic                 jump;
      logic                 mem_to_reg;
      logic                 reg_wr;
      logic                 alu_a_src;
      logic [ALUBSRC_W-1:0] alu_b_src;
      logic [ALUCTR_W-1:0]  alu_ctr;
      logic                 mem_read;
   } ctrl_t;

   // All-zero bundle: an instruction that touches nothing.
   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_reg_sat_counter.sv
// Saturating event counter with a hold input; stops at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             hold,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] count_nxt;

   always_comb begin
      count_nxt = count;
      if (!hold && inc && (count != CNT_MAX)) begin
         count_nxt = count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/stall/load-use squashing and a bubble counter.
module id_ex_reg
   import id_ex_reg_pkg::*;
#(
   parameter int unsigned XLEN  = id_ex_reg_pkg::XLEN,
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 CLoad_Use,
   input  logic                 valid_ID,
   input  logic                 MemWr_ID,
   input  logic                 Branch_ID,
   input  logic                 Jump_ID,
   input  logic                 MemtoReg_ID,
   input  logic                 RegWr_ID,
   input  logic                 ALUASrc_ID,
   input  logic                 MemRead_ID,
   input  logic [ALUBSRC_W-1:0] ALUBSrc_ID,
   input  logic [ALUCTR_W-1:0]  ALUctr_ID,
   input  logic [XLEN-1:0]      pc_ID,
   input  logic [XLEN-1:0]      busA_ID,
   input  logic [XLEN-1:0]      busB_ID,
   input  logic [XLEN-1:0]      imm_ID,
   input  logic [REG_AW-1:0]    rs1_ID,
   input  logic [REG_AW-1:0]    rs2_ID,
   input  logic [REG_AW-1:0]    rd_ID,
   output logic                 valid_EX,
   output logic                 MemWr_EX,
   output logic                 Branch_EX,
   output logic                 Jump_EX,
   output logic                 MemtoReg_EX,
   output logic                 RegWr_EX,
   output logic                 ALUASrc_EX,
   output logic                 MemRead_EX,
   output logic [ALUBSRC_W-1:0] ALUBSrc_EX,
   output logic [ALUCTR_W-1:0]  ALUctr_EX,
   output logic [XLEN-1:0]      pc_EX,
   output logic [XLEN-1:0]      busA_EX,
   output logic [XLEN-1:0]      busB_EX,
   output logic [XLEN-1:0]      imm_EX,
   output logic [REG_AW-1:0]    rs1_EX,
   output logic [REG_AW-1:0]    rs2_EX,
   output logic [REG_AW-1:0]    rd_EX,
   output logic [CNT_W-1:0]     bubble_cnt
);

   ctrl_t               ctrl_id;
   ctrl_t               ctrl_q,  ctrl_nxt;
   logic                valid_q, valid_nxt;
   logic [XLEN-1:0]     pc_q,    pc_nxt;
   logic [XLEN-1:0]     busa_q,  busa_nxt;
   logic [XLEN-1:0]     busb_q,  busb_nxt;
   logic [XLEN-1:0]     imm_q,   imm_nxt;
   logic [REG_AW-1:0]   rs1_q,   rs1_nxt;
   logic [REG_AW-1:0]   rs2_q,   rs2_nxt;
   logic [REG_AW-1:0]   rd_q,    rd_nxt;
   logic                bubble;
   logic                cnt_hold;

   always_comb begin
      ctrl_id            = CTRL_NOP;
      ctrl_id.mem_wr     = MemWr_ID;
      ctrl_id.branch     = Branch_ID;
      ctrl_id.jump       = Jump_ID;
      ctrl_id.mem_to_reg = MemtoReg_ID;
      ctrl_id.reg_wr     = RegWr_ID;
      ctrl_id.alu_a_src  = ALUASrc_ID;
      ctrl_id.alu_b_src  = ALUBSrc_ID;
      ctrl_id.alu_ctr    = ALUctr_ID;
      ctrl_id.mem_read   = MemRead_ID;
   end

   // Next-state selection: flush squashes, stall holds, otherwise load from ID.
   always_comb begin
      ctrl_nxt  = ctrl_q;
      valid_nxt = valid_q;
      pc_nxt    = pc_q;
      busa_nxt  = busa_q;
      busb_nxt  = busb_q;
      imm_nxt   = imm_q;
      rs1_nxt   = rs1_q;
      rs2_nxt   = rs2_q;
      rd_nxt    = rd_q;
      if (flush) begin
         // rd is cleared so the hazard unit never matches a squashed destination.
         ctrl_nxt  = CTRL_NOP;
         valid_nxt = 1'b0;
         rd_nxt    = '0;
      end else if (!stall) begin
         ctrl_nxt  = CLoad_Use ? CTRL_NOP : ctrl_id;
         valid_nxt = valid_ID & ~CLoad_Use;
         pc_nxt    = pc_ID;
         busa_nxt  = busA_ID;
         busb_nxt  = busB_ID;
         imm_nxt   = imm_ID;
         rs1_nxt   = rs1_ID;
         rs2_nxt   = rs2_ID;
         rd_nxt    = rd_ID;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q  <= CTRL_NOP;
         valid_q <= 1'b0;
         pc_q    <= '0;
         busa_q  <= '0;
         busb_q  <= '0;
         imm_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
      end else begin
         ctrl_q  <= ctrl_nxt;
         valid_q <= valid_nxt;
         pc_q    <= pc_nxt;
         busa_q  <= busa_nxt;
         busb_q  <= busb_nxt;
         imm_q   <= imm_nxt;
         rs1_q   <= rs1_nxt;
         rs2_q   <= rs2_nxt;
         rd_q    <= rd_nxt;
      end
   end

   // A bubble is any non-stalled edge that leaves EX invalid.
   assign bubble   = flush | (~stall & (CLoad_Use | ~valid_ID));
   assign cnt_hold = stall & ~flush;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bubble),
      .hold  (cnt_hold),
      .count (bubble_cnt)
   );

   assign valid_EX    = valid_q;
   assign MemWr_EX    = ctrl_q.mem_wr;
   assign Branch_EX   = ctrl_q.branch;
   assign Jump_EX     = ctrl_q.jump;
   assign MemtoReg_EX = ctrl_q.mem_to_reg;
   assign RegWr_EX    = ctrl_q.reg_wr;
   assign ALUASrc_EX  = ctrl_q.alu_a_src;
   assign MemRead_EX  = ctrl_q.mem_read;
   assign ALUBSrc_EX  = ctrl_q.alu_b_src;
   assign ALUctr_EX   = ctrl_q.alu_ctr;
   assign pc_EX       = pc_q;
   assign busA_EX     = busa_q;
   assign busB_EX     = busb_q;
   assign imm_EX      = imm_q;
   assign rs1_EX      = rs1_q;
   assign rs2_EX      = rs2_q;
   assign rd_EX       = rd_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed vector table, reset checks, random run against a model, saturation.
module tb_id_ex_reg;

   logic        clk, rst_n, stall, flush, CLoad_Use, valid_ID;
   logic        MemWr_ID, Branch_ID, Jump_ID, MemtoReg_ID, RegWr_ID, ALUASrc_ID, MemRead_ID;
   logic [1:0]  ALUBSrc_ID;
   logic [3:0]  ALUctr_ID;
   logic [31:0] pc_ID, busA_ID, busB_ID, imm_ID;
   logic [4:0]  rs1_ID, rs2_ID, rd_ID;
   logic        valid_EX, MemWr_EX, Branch_EX, Jump_EX, MemtoReg_EX, RegWr_EX, ALUASrc_EX, MemRead_EX;
   logic [1:0]  ALUBSrc_EX;
   logic [3:0]  ALUctr_EX;
   logic [31:0] pc_EX, busA_EX, busB_EX, imm_EX;
   logic [4:0]  rs1_EX, rs2_EX, rd_EX;
   logic [15:0] bubble_cnt;

   int errors = 0;
   int checks = 0;

   id_ex_reg dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .CLoad_Use(CLoad_Use),
      .valid_ID(valid_ID), .MemWr_ID(MemWr_ID), .Branch_ID(Branch_ID), .Jump_ID(Jump_ID),
      .MemtoReg_ID(MemtoReg_ID), .RegWr_ID(RegWr_ID), .ALUASrc_ID(ALUASrc_ID),
      .MemRead_ID(MemRead_ID), .ALUBSrc_ID(ALUBSrc_ID), .ALUctr_ID(ALUctr_ID),
      .pc_ID(pc_ID), .busA_ID(busA_ID), .busB_ID(busB_ID), .imm_ID(imm_ID),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
      .valid_EX(valid_EX), .MemWr_EX(MemWr_EX), .Branch_EX(Branch_EX), .Jump_EX(Jump_EX),
      .MemtoReg_EX(MemtoReg_EX), .RegWr_EX(RegWr_EX), .ALUASrc_EX(ALUASrc_EX),
      .MemRead_EX(MemRead_EX), .ALUBSrc_EX(ALUBSrc_EX), .ALUctr_EX(ALUctr_EX),
      .pc_EX(pc_EX), .busA_EX(busA_EX), .busB_EX(busB_EX), .imm_EX(imm_EX),
      .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX), .bubble_cnt(bubble_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference state of the EX stage as the rules describe it.
   typedef struct {
      logic        memwr, branch, jump, memtoreg, regwr, aluasrc, memread, valid;
      logic [1:0]  alubsrc;
      logic [3:0]  aluctr;
      logic [31:0] pc, busa, busb, imm;
      logic [4:0]  rs1, rs2, rd;
      int          cnt;
   } model_t;

   model_t m;

   typedef struct {
      logic        stall, flush, lu, valid, regwr;
      logic [3:0]  ctr;
      logic [4:0]  rd;
      logic [31:0] busa;
      logic        e_regwr;
      logic [3:0]  e_ctr;
      logic [4:0]  e_rd;
      logic [31:0] e_busa;
      logic        e_valid;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m = '{default: '0, cnt: 0};
   endtask

   function automatic void bump();
      if (m.cnt < 65535) m.cnt = m.cnt + 1;
   endfunction

   // Advance the model by one rising edge using the inputs currently applied.
   task automatic model_edge();
      if (flush) begin
         {m.memwr, m.branch, m.jump, m.memtoreg, m.regwr, m.aluasrc, m.memread} = '0;
         m.alubsrc = 0; m.aluctr = 0; m.valid = 0; m.rd = 0;
         bump();
      end else if (!stall) begin
         m.memwr    = MemWr_ID    & ~CLoad_Use;
         m.branch   = Branch_ID   & ~CLoad_Use;
         m.jump     = Jump_ID     & ~CLoad_Use;
         m.memtoreg = MemtoReg_ID & ~CLoad_Use;
         m.regwr    = RegWr_ID    & ~CLoad_Use;
         m.aluasrc  = ALUASrc_ID  & ~CLoad_Use;
         m.memread  = MemRead_ID  & ~CLoad_Use;
         m.alubsrc  = CLoad_Use ? 2'd0 : ALUBSrc_ID;
         m.aluctr   = CLoad_Use ? 4'd0 : ALUctr_ID;
         m.valid    = valid_ID & ~CLoad_Use;
         m.pc = pc_ID; m.busa = busA_ID; m.busb = busB_ID; m.imm = imm_ID;
         m.rs1 = rs1_ID; m.rs2 = rs2_ID; m.rd = rd_ID;
         if (!m.valid) bump();
      end
   endtask

   task automatic check_model();
      chk("valid_EX",    32'(valid_EX),    32'(m.valid));
      chk("MemWr_EX",    32'(MemWr_EX),    32'(m.memwr));
      chk("Branch_EX",   32'(Branch_EX),   32'(m.branch));
      chk("Jump_EX",     32'(Jump_EX),     32'(m.jump));
      chk("MemtoReg_EX", 32'(MemtoReg_EX), 32'(m.memtoreg));
      chk("RegWr_EX",    32'(RegWr_EX),    32'(m.regwr));
      chk("ALUASrc_EX",  32'(ALUASrc_EX),  32'(m.aluasrc));
      chk("MemRead_EX",  32'(MemRead_EX),  32'(m.memread));
      chk("ALUBSrc_EX",  32'(ALUBSrc_EX),  32'(m.alubsrc));
      chk("ALUctr_EX",   32'(ALUctr_EX),   32'(m.aluctr));
      chk("pc_EX",       pc_EX,            m.pc);
      chk("busA_EX",     busA_EX,          m.busa);
      chk("busB_EX",     busB_EX,          m.busb);
      chk("imm_EX",      imm_EX,           m.imm);
      chk("rs1_EX",      32'(rs1_EX),      32'(m.rs1));
      chk("rs2_EX",      32'(rs2_EX),      32'(m.rs2));
      chk("rd_EX",       32'(rd_EX),       32'(m.rd));
      chk("bubble_cnt",  32'(bubble_cnt),  32'(m.cnt));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " valid_EX"},   32'(valid_EX), 32'd0);
      chk({tag, " controls"},   32'({MemWr_EX, Branch_EX, Jump_EX, MemtoReg_EX, RegWr_EX,
                                       ALUASrc_EX, MemRead_EX, ALUBSrc_EX, ALUctr_EX}), 32'd0);
      chk({tag, " data"},       pc_EX | busA_EX | busB_EX | imm_EX, 32'd0);
      chk({tag, " regs"},       32'({rs1_EX, rs2_EX, rd_EX}), 32'd0);
      chk({tag, " bubble_cnt"}, 32'(bubble_cnt), 32'd0);
   endtask

   task automatic clear_inputs();
      {stall, flush, CLoad_Use, valid_ID} = '0;
      {MemWr_ID, Branch_ID, Jump_ID, MemtoReg_ID, RegWr_ID, ALUASrc_ID, MemRead_ID} = '0;
      ALUBSrc_ID = '0; ALUctr_ID = '0;
      pc_ID = '0; busA_ID = '0; busB_ID = '0; imm_ID = '0;
      rs1_ID = '0; rs2_ID = '0; rd_ID = '0;
   endtask

   task automatic tick(input bit do_chk);
      model_edge();
      @(posedge clk);
      #1;
      if (do_chk) check_model();
   endtask

   task automatic randomize_inputs();
      stall       = ($urandom_range(0, 99) < 25);
      flush       = ($urandom_range(0, 99) < 15);
      CLoad_Use   = ($urandom_range(0, 99) < 20);
      valid_ID    = ($urandom_range(0, 99) < 75);
      MemWr_ID    = 1'($urandom);
      Branch_ID   = 1'($urandom);
      Jump_ID     = 1'($urandom);
      MemtoReg_ID = 1'($urandom);
      RegWr_ID    = 1'($urandom);
      ALUASrc_ID  = 1'($urandom);
      MemRead_ID  = 1'($urandom);
      ALUBSrc_ID  = 2'($urandom);
      ALUctr_ID   = 4'($urandom);
      pc_ID = $urandom; busA_ID = $urandom; busB_ID = $urandom; imm_ID = $urandom;
      rs1_ID = 5'($urandom); rs2_ID = 5'($urandom); rd_ID = 5'($urandom);
   endtask

   initial begin
      //            stall flush lu  vld rw  ctr    rd     busA            e_rw e_ctr  e_rd   e_busA        e_v e_cnt
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 5'd7,  32'h1234, 1'b1, 4'h3, 5'd7,  32'h1234, 1'b1, 16'd0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 5'd7,  32'h1234, 1'b0, 4'h0, 5'd7,  32'h1234, 1'b0, 16'd1};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 5'd9,  32'h5555, 1'b1, 4'h5, 5'd9,  32'h5555, 1'b1, 16'd1};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 5'd3,  32'hAAAA, 1'b1, 4'h5, 5'd9,  32'h5555, 1'b1, 16'd1};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hE, 5'd4,  32'hBBBB, 1'b1, 4'h5, 5'd9,  32'h5555, 1'b1, 16'd1};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hD, 5'd5,  32'hCCCC, 1'b1, 4'h5, 5'd9,  32'h5555, 1'b1, 16'd1};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h7, 5'd6,  32'hDDDD, 1'b0, 4'h0, 5'd0,  32'h5555, 1'b0, 16'd2};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 5'd4,  32'h7777, 1'b1, 4'h2, 5'd4,  32'h7777, 1'b0, 16'd3};

      clear_inputs();
      rst_n = 1'b0;
      #2;
      check_all_zero("reset_initial");
      #5 rst_n = 1'b1;

      // Directed table: load, load-use, stall x3, stall+flush, invalid load.
      foreach (vecs[i]) begin
         clear_inputs();
         stall = vecs[i].stall; flush = vecs[i].flush; CLoad_Use = vecs[i].lu;
         valid_ID = vecs[i].valid; RegWr_ID = vecs[i].regwr; ALUctr_ID = vecs[i].ctr;
         rd_ID = vecs[i].rd; busA_ID = vecs[i].busa;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d RegWr_EX", i),   32'(RegWr_EX),   32'(vecs[i].e_regwr));
         chk($sformatf("vec%0d ALUctr_EX", i),  32'(ALUctr_EX),  32'(vecs[i].e_ctr));
         chk($sformatf("vec%0d rd_EX", i),      32'(rd_EX),      32'(vecs[i].e_rd));
         chk($sformatf("vec%0d busA_EX", i),    busA_EX,         vecs[i].e_busa);
         chk($sformatf("vec%0d valid_EX", i),   32'(valid_EX),   32'(vecs[i].e_valid));
         chk($sformatf("vec%0d bubble_cnt", i), 32'(bubble_cnt), 32'(vecs[i].e_cnt));
      end

      // Asynchronous reset mid-cycle while stall and flush are both requested.
      #3;
      stall = 1'b1; flush = 1'b1;
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_async");
      @(posedge clk);
      #1;
      check_all_zero("reset_over_edge");
      model_reset();
      rst_n = 1'b1;
      flush = 1'b0;
      tick(1'b1);
      clear_inputs();
      valid_ID = 1'b1; RegWr_ID = 1'b1; rd_ID = 5'd12; busA_ID = 32'hCAFE_F00D;
      tick(1'b1);

      for (int n = 0; n < 300; n++) begin
         randomize_inputs();
         tick(1'b1);
      end

      // Saturation: pile up bubbles to one below the ceiling, then cross it.
      clear_inputs();
      while (m.cnt < 65534) tick(1'b0);
      check_model();
      chk("sat_preload", 32'(bubble_cnt), 32'h0000_FFFE);
      for (int k = 0; k < 3; k++) begin
         flush = (k == 1);
         tick(1'b1);
         chk($sformatf("sat_edge%0d", k), 32'(bubble_cnt), 32'h0000_FFFF);
      end
      flush = 1'b0; valid_ID = 1'b1;
      tick(1'b1);
      chk("sat_after_load", 32'(bubble_cnt), 32'h0000_FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
